// File: rtl/svc_uart_tx_arb_pkg.sv
// Shared types for the UART TX arbiter: grant states and owner encodings.
package svc_uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_DBG = 2'd1,
    ST_GNT_APP = 2'd2
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_DBG  = 2'd1;
  localparam logic [1:0] OWNER_APP  = 2'd2;

  function automatic logic [1:0] state_to_owner(input arb_state_t s);
    case (s)
      ST_GNT_DBG: return OWNER_DBG;
      ST_GNT_APP: return OWNER_APP;
      default:    return OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/svc_uart_tx_arb_fifo.sv
// Byte-wide synchronous FIFO with show-ahead read data and occupancy count.
module svc_uart_tx_arb_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic [7:0]      i_data,
  input  logic            i_pop,
  output logic [7:0]      o_data,
  output logic            o_full,
  output logic            o_empty,
  output logic [ADDR_W:0] o_count
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == DEPTH_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally at DEPTH because they are exactly ADDR_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/svc_uart_tx_arb.sv
// Shares one svc_uart_tx between the debug bridge and the application UART.
// Grants are frame-locked: released only after an idle gap or a burst limit.
module svc_uart_tx_arb
  import svc_uart_tx_arb_pkg::*;
#(
  parameter int APP_FIFO_ADDR_W = 4,
  parameter int IDLE_CYCLES     = 64,
  parameter int MAX_BURST       = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dbg_valid,
  input  logic [7:0]               dbg_data,
  output logic                     dbg_ready,
  input  logic                     app_valid,
  input  logic [7:0]               app_data,
  output logic                     app_ready,
  output logic                     utx_valid,
  output logic [7:0]               utx_data,
  input  logic                     utx_ready,
  output logic [1:0]               owner,
  output logic [APP_FIFO_ADDR_W:0] app_fifo_cnt
);
  localparam int  IDLE_W   = $clog2(IDLE_CYCLES + 1);
  localparam int  BURST_W  = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam bit  BURST_EN = (MAX_BURST > 0);
  localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [IDLE_W-1:0]  IDLE_SAT  = IDLE_W'(IDLE_CYCLES);
  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'((MAX_BURST > 0) ? MAX_BURST : 1);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [IDLE_W-1:0]  r_idle_cnt;
  logic [BURST_W-1:0] r_burst_cnt;
  logic               r_utx_valid;
  logic [7:0]         r_utx_data;

  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic [7:0] w_fifo_data;
  logic       w_push;
  logic       w_slot_free;
  logic       w_other_pending;
  logic       w_switch;
  logic       w_dbg_acc;
  logic       w_app_acc;
  logic       w_acc;
  logic       w_idle_done;

  svc_uart_tx_arb_fifo #(.ADDR_W(APP_FIFO_ADDR_W)) u_app_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (app_data),
    .i_pop   (w_app_acc),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (app_fifo_cnt)
  );

  assign app_ready   = !rst && !w_fifo_full;
  assign w_push      = app_valid && app_ready;
  assign w_slot_free = !r_utx_valid || utx_ready;

  assign w_other_pending = (r_state == ST_GNT_DBG) ? !w_fifo_empty :
                           (r_state == ST_GNT_APP) ? dbg_valid : 1'b0;
  assign w_switch = BURST_EN && (r_burst_cnt == BURST_LIM) && w_other_pending;

  // Accepts are held off during the switch cycle so a burst never exceeds the limit.
  assign dbg_ready   = (r_state == ST_GNT_DBG) && w_slot_free && !w_switch;
  assign w_dbg_acc   = dbg_valid && dbg_ready;
  assign w_app_acc   = (r_state == ST_GNT_APP) && !w_fifo_empty && w_slot_free && !w_switch;
  assign w_acc       = w_dbg_acc || w_app_acc;
  assign w_idle_done = !w_acc && (r_idle_cnt == IDLE_LAST);

  assign utx_valid = r_utx_valid;
  assign utx_data  = r_utx_data;
  assign owner     = state_to_owner(r_state);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (dbg_valid)          w_state_nxt = ST_GNT_DBG;
        else if (!w_fifo_empty) w_state_nxt = ST_GNT_APP;
      end
      ST_GNT_DBG: begin
        if (w_switch)         w_state_nxt = ST_GNT_APP;
        else if (w_idle_done) w_state_nxt = ST_IDLE;
      end
      ST_GNT_APP: begin
        if (w_switch)         w_state_nxt = ST_GNT_DBG;
        else if (w_idle_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt  <= '0;
      r_burst_cnt <= '0;
    end else if (r_state == ST_IDLE || w_switch) begin
      r_idle_cnt  <= '0;
      r_burst_cnt <= '0;
    end else if (w_acc) begin
      r_idle_cnt <= '0;
      if (r_burst_cnt != BURST_LIM) r_burst_cnt <= r_burst_cnt + 1'b1;
    end else if (r_idle_cnt != IDLE_SAT) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_utx_valid <= 1'b0;
      r_utx_data  <= '0;
    end else if (w_acc) begin
      r_utx_valid <= 1'b1;
      r_utx_data  <= w_dbg_acc ? dbg_data : w_fifo_data;
    end else if (utx_ready) begin
      r_utx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_svc_uart_tx_arb.sv
// Scoreboard bench for svc_uart_tx_arb: expected byte order comes from a
// chunked round-robin model of the two streams; a monitor checks utx handshakes.
module tb_svc_uart_tx_arb;
  localparam int AW   = 4;
  localparam int IDLE = 8;
  localparam int MB   = 4;

  logic clk = 1'b0;
  logic rst;
  logic dbg_valid, dbg_ready, app_valid, app_ready, utx_valid, utx_ready;
  logic [7:0] dbg_data, app_data, utx_data;
  logic [1:0] owner;
  logic [AW:0] app_fifo_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_dbg[$];
  logic [7:0] tx_app[$];
  bit rnd_ready = 1'b0;
  int stall_run = 0;

  always #5 clk = ~clk;

  svc_uart_tx_arb #(.APP_FIFO_ADDR_W(AW), .IDLE_CYCLES(IDLE), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .app_valid(app_valid), .app_data(app_data), .app_ready(app_ready),
    .utx_valid(utx_valid), .utx_data(utx_data), .utx_ready(utx_ready),
    .owner(owner), .app_fifo_cnt(app_fifo_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output byte must be the next expected one.
  always @(negedge clk) begin
    if (!rst && utx_valid && utx_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL utx_unexpected: got 0x%0h, want no byte at %0t", utx_data, $time);
      end else begin
        chk("utx_data", {24'd0, utx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Random serializer back-pressure, stall runs kept well below IDLE.
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      if (stall_run >= 3 || $urandom_range(0, 3) != 0) begin
        utx_ready = 1'b1;
        stall_run = 0;
      end else begin
        utx_ready = 1'b0;
        stall_run++;
      end
    end
  end

  // Whole-stream reference: while both streams have bytes, they alternate in
  // chunks of MB starting with debug; once one side is empty the other drains.
  function automatic void model_order();
    int di, ai, take;
    bit cur_dbg;
    di = 0; ai = 0; cur_dbg = 1'b1;
    while (di < tx_dbg.size() || ai < tx_app.size()) begin
      if (cur_dbg) begin
        take = tx_dbg.size() - di;
        if (ai < tx_app.size() && take > MB) take = MB;
        for (int k = 0; k < take; k++) begin exp_q.push_back(tx_dbg[di]); di++; end
      end else begin
        take = tx_app.size() - ai;
        if (di < tx_dbg.size() && take > MB) take = MB;
        for (int k = 0; k < take; k++) begin exp_q.push_back(tx_app[ai]); ai++; end
      end
      cur_dbg = !cur_dbg;
    end
  endfunction

  task automatic send_dbg(input logic [7:0] b, input bit last);
    bit hs;
    int t;
    hs = 1'b0; t = 0;
    dbg_valid = 1'b1;
    dbg_data  = b;
    while (!hs && t < 400) begin
      @(negedge clk); hs = dbg_ready;
      @(posedge clk); #1; t++;
    end
    if (!hs) begin
      n_cmp++; n_err++;
      $display("FAIL dbg_handshake_timeout: byte 0x%0h not accepted, want accept within 400 cycles", b);
    end
    if (last || !hs) dbg_valid = 1'b0;
  endtask

  task automatic send_app(input logic [7:0] b, input bit last);
    bit hs;
    int t;
    hs = 1'b0; t = 0;
    app_valid = 1'b1;
    app_data  = b;
    while (!hs && t < 400) begin
      @(negedge clk); hs = app_ready;
      @(posedge clk); #1; t++;
    end
    if (!hs) begin
      n_cmp++; n_err++;
      $display("FAIL app_handshake_timeout: byte 0x%0h not accepted, want accept within 400 cycles", b);
    end
    if (last || !hs) app_valid = 1'b0;
  endtask

  task automatic dbg_stream();
    for (int i = 0; i < tx_dbg.size(); i++) send_dbg(tx_dbg[i], i == tx_dbg.size() - 1);
  endtask

  task automatic app_stream(input int delay);
    repeat (delay) begin @(posedge clk); #1; end
    for (int i = 0; i < tx_app.size(); i++) send_app(tx_app[i], i == tx_app.size() - 1);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || owner != 2'd0) && t < 500) begin
      @(posedge clk); #1; t++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_owner_idle"}, {30'd0, owner}, 0);
    exp_q.delete();
  endtask

  task automatic run_case(input string name, input int app_delay);
    model_order();
    fork
      dbg_stream();
      app_stream(app_delay);
    join
    wait_idle(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    dbg_valid = 1'b0; dbg_data = '0;
    app_valid = 1'b0; app_data = '0;
    utx_ready = 1'b1;
    #1;
    chk("rst_utx_valid", {31'd0, utx_valid}, 0);
    chk("rst_utx_data", {24'd0, utx_data}, 0);
    chk("rst_owner", {30'd0, owner}, 0);
    chk("rst_dbg_ready", {31'd0, dbg_ready}, 0);
    chk("rst_app_ready", {31'd0, app_ready}, 0);
    chk("rst_fifo_cnt", {27'd0, app_fifo_cnt}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_app_ready", {31'd0, app_ready}, 1);

    // Debug only, then grant release exactly IDLE idle clocks after the last byte.
    tx_dbg = '{8'h41, 8'h42};
    tx_app.delete();
    model_order();
    dbg_stream();
    chk("s1_owner_busy", {30'd0, owner}, 1);
    repeat (IDLE - 1) @(posedge clk);
    #1;
    chk("s1_owner_before_release", {30'd0, owner}, 1);
    @(posedge clk); #1;
    chk("s1_owner_released", {30'd0, owner}, 0);
    wait_idle("s1");

    // Contention from IDLE: debug wins, app byte follows after release.
    tx_dbg = '{8'h11};
    tx_app = '{8'h55};
    run_case("s2", 0);

    // Frame lock: debug bytes with short gaps keep the grant over a queued app byte.
    exp_q = '{8'h10, 8'h12, 8'h13, 8'h99};
    send_dbg(8'h10, 1'b1);
    send_app(8'h99, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    send_dbg(8'h12, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    send_dbg(8'h13, 1'b1);
    wait_idle("s3");

    // Burst limit with both sides pending.
    tx_dbg.delete(); tx_app.delete();
    for (int i = 0; i < 10; i++) tx_dbg.push_back(8'hD0 + 8'(i));
    for (int i = 0; i < 6; i++)  tx_app.push_back(8'hA0 + 8'(i));
    run_case("s4", 2);

    // FIFO full while a debug byte is stuck in the output register.
    tx_dbg = '{8'h33};
    tx_app.delete();
    for (int i = 0; i < 17; i++) tx_app.push_back(8'h60 + 8'(i));
    model_order();
    utx_ready = 1'b0;
    send_dbg(8'h33, 1'b1);
    fork
      app_stream(0);
      begin
        int t;
        t = 0;
        while (app_fifo_cnt != 5'd16 && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        chk("s5_full_cnt", {27'd0, app_fifo_cnt}, 16);
        chk("s5_full_ready", {31'd0, app_ready}, 0);
        repeat (5) @(negedge clk);
        chk("s5_full_hold_cnt", {27'd0, app_fifo_cnt}, 16);
        chk("s5_held_utx_data", {24'd0, utx_data}, 32'h33);
        chk("s5_held_utx_valid", {31'd0, utx_valid}, 1);
        @(posedge clk); #1;
        utx_ready = 1'b1;
      end
    join
    wait_idle("s5");

    // Async reset in mid-transfer with the serializer stalled.
    utx_ready = 1'b0;
    send_dbg(8'hA5, 1'b1);
    send_app(8'h01, 1'b0);
    send_app(8'h02, 1'b0);
    send_app(8'h03, 1'b1);
    @(negedge clk);
    chk("s6_pre_utx_valid", {31'd0, utx_valid}, 1);
    chk("s6_pre_fifo_cnt", {27'd0, app_fifo_cnt}, 3);
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_utx_valid", {31'd0, utx_valid}, 0);
    chk("s6_rst_owner", {30'd0, owner}, 0);
    chk("s6_rst_fifo_cnt", {27'd0, app_fifo_cnt}, 0);
    chk("s6_rst_app_ready", {31'd0, app_ready}, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("s6_post_app_ready", {31'd0, app_ready}, 1);
    utx_ready = 1'b1;
    tx_dbg = '{8'h5A};
    tx_app = '{8'hC3};
    run_case("s6", 1);

    // Randomized streams with random serializer back-pressure.
    rnd_ready = 1'b1;
    for (int it = 0; it < 25; it++) begin
      int nd, na;
      nd = $urandom_range(1, 14);
      na = $urandom_range(1, 12);
      tx_dbg.delete(); tx_app.delete();
      for (int i = 0; i < nd; i++) tx_dbg.push_back(8'($urandom));
      for (int i = 0; i < na; i++) tx_app.push_back(8'($urandom));
      run_case("rnd", $urandom_range(0, 3));
    end
    rnd_ready = 1'b0;
    @(posedge clk); #2;
    utx_ready = 1'b1;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
